// File: rtl/hazard_ctrl_mdu.sv
// hazard_ctrl_mdu
//   Hazard and forwarding controller for the 5-stage F/D/E/M/W MIPS pipeline.
//   - Selects forwarded operands for the D (branch/compare), E (ALU) and
//     M (store data) stages.
//   - Generates D/E stalls, front-end enables and bubble flushes.
//   - Keeps a short history of retired W writes so that E/M can still
//     forward a value that has already left the pipeline.
//   - Tracks multi-cycle MDU occupancy and counts stall cycles.
// Ports
//   Clk, Reset                  clock (rising edge), synchronous active-high reset
//   A1D/A2D, D1Use/D2Use        D source registers and use flags
//   RD1D/RD2D                   register file read data in D
//   MDUOpD                      D instruction needs the MDU or HI/LO
//   A1E/A2E, E1Use/E2Use        E source registers and use flags
//   RD1E/RD2E                   E pipelined read data
//   MDUStartE                   00 none, 01 mult, 10 div, 11 none
//   A3E/WDE/WDEVld              E destination, result, result valid
//   A3M/WDM/WDMVld              M destination, result, result valid
//   A2M/RD2M                    M store-data source and pipelined data
//   A3W/WDW                     W destination and write data
//   ForwardD1/D2/E1/E2/M2       forwarded operands
//   PCEn/DRegEn/ERegEn          stage enables
//   ERegFlush/MRegFlush         bubble inserts into E and M
//   MDUBusy                     MDU occupied or being started this cycle
//   StallCnt                    saturating count of stalled cycles
module hazard_ctrl_mdu #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned HIST_DEPTH = 1,
  parameter int unsigned MULT_LAT   = 5,
  parameter int unsigned DIV_LAT    = 10,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [AW-1:0]    A1D,
  input  logic [AW-1:0]    A2D,
  input  logic             D1Use,
  input  logic             D2Use,
  input  logic [DW-1:0]    RD1D,
  input  logic [DW-1:0]    RD2D,
  input  logic             MDUOpD,
  input  logic [AW-1:0]    A1E,
  input  logic [AW-1:0]    A2E,
  input  logic             E1Use,
  input  logic             E2Use,
  input  logic [DW-1:0]    RD1E,
  input  logic [DW-1:0]    RD2E,
  input  logic [1:0]       MDUStartE,
  input  logic [AW-1:0]    A3E,
  input  logic [DW-1:0]    WDE,
  input  logic             WDEVld,
  input  logic [AW-1:0]    A3M,
  input  logic [DW-1:0]    WDM,
  input  logic             WDMVld,
  input  logic [AW-1:0]    A2M,
  input  logic [DW-1:0]    RD2M,
  input  logic [AW-1:0]    A3W,
  input  logic [DW-1:0]    WDW,
  output logic [DW-1:0]    ForwardD1,
  output logic [DW-1:0]    ForwardD2,
  output logic [DW-1:0]    ForwardE1,
  output logic [DW-1:0]    ForwardE2,
  output logic [DW-1:0]    ForwardM2,
  output logic             PCEn,
  output logic             DRegEn,
  output logic             ERegEn,
  output logic             ERegFlush,
  output logic             MRegFlush,
  output logic             MDUBusy,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned MCW     = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {
    MDU_NONE = 2'b00,
    MDU_MULT = 2'b01,
    MDU_DIV  = 2'b10,
    MDU_RSVD = 2'b11
  } mdu_op_e;

  function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] d);
    return (a == d) && (d != '0);
  endfunction

  mdu_op_e            mdu_op;
  logic               mdu_req;
  logic               stall_e;
  logic               stall_d;
  logic               h1;
  logic               h2;
  logic [MCW-1:0]     mcnt_q,   mcnt_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [AW-1:0]      hist_a_q [HIST_DEPTH];
  logic [AW-1:0]      hist_a_d [HIST_DEPTH];
  logic [DW-1:0]      hist_w_q [HIST_DEPTH];
  logic [DW-1:0]      hist_w_d [HIST_DEPTH];

  assign mdu_op  = mdu_op_e'(MDUStartE);
  assign mdu_req = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);

  // Hazard detection and pipeline control
  always_comb begin
    stall_e = (E1Use && match(A1E, A3M) && !WDMVld) ||
              (E2Use && match(A2E, A3M) && !WDMVld);
    // An unready E producer shadows any M producer of the same register.
    h1 = D1Use && ((match(A1D, A3E) && !WDEVld) ||
                   (match(A1D, A3M) && !match(A1D, A3E) && !WDMVld));
    h2 = D2Use && ((match(A2D, A3E) && !WDEVld) ||
                   (match(A2D, A3M) && !match(A2D, A3E) && !WDMVld));
    MDUBusy   = (mcnt_q != '0) || mdu_req;
    // E stall freezes D too, so a concurrent D hazard must not also flush E.
    stall_d   = (h1 || h2 || (MDUOpD && MDUBusy)) && !stall_e;
    PCEn      = !(stall_d || stall_e);
    DRegEn    = !(stall_d || stall_e);
    ERegEn    = !stall_e;
    ERegFlush = stall_d;
    MRegFlush = stall_e;
  end

  // Forwarding muxes
  always_comb begin
    ForwardD1 = match(A1D, A3E) ? WDE : match(A1D, A3M) ? WDM : RD1D;
    ForwardD2 = match(A2D, A3E) ? WDE : match(A2D, A3M) ? WDM : RD2D;
    ForwardE1 = RD1E;
    ForwardE2 = RD2E;
    ForwardM2 = RD2M;
    // Walk oldest to newest so younger sources override older ones.
    for (int unsigned i = HIST_DEPTH; i > 0; i--) begin
      if (match(A1E, hist_a_q[i-1])) ForwardE1 = hist_w_q[i-1];
      if (match(A2E, hist_a_q[i-1])) ForwardE2 = hist_w_q[i-1];
      if (match(A2M, hist_a_q[i-1])) ForwardM2 = hist_w_q[i-1];
    end
    if (match(A1E, A3W)) ForwardE1 = WDW;
    if (match(A2E, A3W)) ForwardE2 = WDW;
    if (match(A2M, A3W)) ForwardM2 = WDW;
    if (match(A1E, A3M)) ForwardE1 = WDM;
    if (match(A2E, A3M)) ForwardE2 = WDM;
  end

  // Next-state: MDU counter, stall counter, write history
  always_comb begin
    mcnt_d = mcnt_q;
    if (mdu_req && !stall_e) begin
      mcnt_d = (mdu_op == MDU_MULT) ? MCW'(MULT_LAT) : MCW'(DIV_LAT);
    end else if (mcnt_q != '0) begin
      mcnt_d = mcnt_q - MCW'(1);
    end

    cnt_d = cnt_q;
    if ((stall_d || stall_e) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    hist_a_d[0] = A3W;
    hist_w_d[0] = WDW;
    for (int unsigned i = 1; i < HIST_DEPTH; i++) begin
      hist_a_d[i] = hist_a_q[i-1];
      hist_w_d[i] = hist_w_q[i-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcnt_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
        hist_a_q[i] <= '0;
        hist_w_q[i] <= '0;
      end
    end else begin
      mcnt_q <= mcnt_d;
      cnt_q  <= cnt_d;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
        hist_a_q[i] <= hist_a_d[i];
        hist_w_q[i] <= hist_w_d[i];
      end
    end
  end

  assign StallCnt = cnt_q;

endmodule
